systolic_job_sched: RTL and testbench

//  Job scheduler/sequencer for the NxN weight-stationary systolic array: accepts one job descriptor,

---
 rtl/systolic_job_sched_if.sv | 73 +++++++
 rtl/systolic_job_sched.sv | 193 +++++++++++++++++++
 tb/tb_systolic_job_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_job_sched_if.sv
// systolic_job_sched_if
//   Groups the host streams (job descriptor, weight rows, input vectors and
//   result rows) with the array control/data pins of the job scheduler.
//   Modports:
//     slave  - the scheduler side (systolic_job_sched)
//     master - the environment side (host streams plus the array)
//   Signals: job_valid/job_ready/job_nvec/job_err, wt_valid/wt_ready/wt_data,
//   in_valid/in_ready/in_data, arr_clr/arr_wt_load/arr_wt_row/arr_wt_data,
//   arr_in_data/arr_in_lv, arr_res_sel/arr_res, res_valid/res_ready/res_data/
//   res_row, busy, done.
//   Optional: SYSTOLIC_SCHED_ABORT_EN adds abort (to scheduler) and aborted.
interface systolic_job_sched_if #(
  parameter int N       = 4,
  parameter int DW      = 4,
  parameter int ACCW    = 8,
  parameter int VEC_MAX = 16
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int VW = $clog2(VEC_MAX + 1);

  logic              job_valid;
  logic              job_ready;
  logic [VW-1:0]     job_nvec;
  logic              job_err;
  logic              wt_valid;
  logic              wt_ready;
  logic [N*DW-1:0]   wt_data;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   in_data;
  logic              arr_clr;
  logic              arr_wt_load;
  logic [RW-1:0]     arr_wt_row;
  logic [N*DW-1:0]   arr_wt_data;
  logic [N*DW-1:0]   arr_in_data;
  logic [N-1:0]      arr_in_lv;
  logic [RW-1:0]     arr_res_sel;
  logic [N*ACCW-1:0] arr_res;
  logic              res_valid;
  logic              res_ready;
  logic [N*ACCW-1:0] res_data;
  logic [RW-1:0]     res_row;
  logic              busy;
  logic              done;
`ifdef SYSTOLIC_SCHED_ABORT_EN
  logic              abort;
  logic              aborted;
`endif

  modport slave (
`ifdef SYSTOLIC_SCHED_ABORT_EN
    input  abort,
    output aborted,
`endif
    input  job_valid, job_nvec, wt_valid, wt_data, in_valid, in_data,
           arr_res, res_ready,
    output job_ready, job_err, wt_ready, in_ready, arr_clr, arr_wt_load,
           arr_wt_row, arr_wt_data, arr_in_data, arr_in_lv, arr_res_sel,
           res_valid, res_data, res_row, busy, done
  );

  modport master (
`ifdef SYSTOLIC_SCHED_ABORT_EN
    output abort,
    input  aborted,
`endif
    output job_valid, job_nvec, wt_valid, wt_data, in_valid, in_data,
           arr_res, res_ready,
    input  job_ready, job_err, wt_ready, in_ready, arr_clr, arr_wt_load,
           arr_wt_row, arr_wt_data, arr_in_data, arr_in_lv, arr_res_sel,
           res_valid, res_data, res_row, busy, done
  );
endinterface

// File: rtl/systolic_job_sched.sv
// systolic_job_sched
//   Sequences one job on an NxN weight-stationary systolic array:
//   IDLE -> CLEAR -> LOAD_W -> STREAM -> FLUSH -> DRAIN -> DONE -> IDLE.
//   Clears the array, loads N weight rows, streams input vectors with a
//   per-lane diagonal skew (lane k delayed k+1 cycles), waits for the array
//   to settle, then drains N result rows over a valid/ready port.
//   Ports: clk, reset (async, active high), bus (systolic_job_sched_if.slave).
//   Optional feature macro: SYSTOLIC_SCHED_ABORT_EN (abort input / aborted pulse).
module systolic_job_sched #(
  parameter int N       = 4,
  parameter int DW      = 4,
  parameter int ACCW    = 8,
  parameter int VEC_MAX = 16,
  parameter int ARR_LAT = 4
) (
  input logic                 clk,
  input logic                 reset,
  systolic_job_sched_if.slave bus
);
  localparam int RW        = (N > 1) ? $clog2(N) : 1;
  localparam int VW        = $clog2(VEC_MAX + 1);
  localparam int FLUSH_LEN = (N - 1) + ARR_LAT;
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD_W, STREAM, FLUSH, DRAIN, DONE, ABORTED
  } state_t;

  state_t          state_reg, state_next;
  logic [VW-1:0]   nvec_reg;
  logic [VW-1:0]   vec_cnt_reg;
  logic [RW-1:0]   row_cnt_reg;   // weight row count in LOAD_W, result row in DRAIN
  logic [FW-1:0]   flush_cnt_reg;
  logic            job_err_reg;
  logic            wt_load_reg;
  logic [RW-1:0]   wt_row_reg;
  logic [N*DW-1:0] wt_data_reg;
  logic [N*DW-1:0] lane_data;
  logic [N-1:0]    lane_lv;

  logic nvec_ok, job_take, wt_beat, in_beat, res_beat;
  logic last_row, last_vec, flush_end, abort_hit;

`ifdef SYSTOLIC_SCHED_ABORT_EN
  assign abort_hit = bus.abort && (state_reg != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // An abort in the same cycle wins over any handshake completing.
  assign nvec_ok   = (bus.job_nvec != '0) && (bus.job_nvec <= VW'(VEC_MAX));
  assign job_take  = (state_reg == IDLE) && bus.job_valid && nvec_ok;
  assign wt_beat   = (state_reg == LOAD_W) && bus.wt_valid && !abort_hit;
  assign in_beat   = (state_reg == STREAM) && bus.in_valid && !abort_hit;
  assign res_beat  = (state_reg == DRAIN) && bus.res_ready && !abort_hit;
  assign last_row  = (row_cnt_reg == RW'(N - 1));
  assign last_vec  = (vec_cnt_reg == nvec_reg - VW'(1));
  assign flush_end = (flush_cnt_reg == FW'(FLUSH_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state plus all state-decoded outputs; readies never depend on valids.
  always_comb begin
    state_next    = state_reg;
    bus.job_ready = 1'b0;
    bus.wt_ready  = 1'b0;
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    bus.arr_clr   = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = (state_reg != IDLE);
`ifdef SYSTOLIC_SCHED_ABORT_EN
    bus.aborted   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        bus.job_ready = 1'b1;
        if (job_take) state_next = CLEAR;
      end
      CLEAR: begin
        bus.arr_clr = 1'b1;
        state_next  = LOAD_W;
      end
      LOAD_W: begin
        bus.wt_ready = 1'b1;
        if (wt_beat && last_row) state_next = STREAM;
      end
      STREAM: begin
        bus.in_ready = 1'b1;
        if (in_beat && last_vec) state_next = FLUSH;
      end
      FLUSH: begin
        if (flush_end) state_next = DRAIN;
      end
      DRAIN: begin
        bus.res_valid = 1'b1;
        if (res_beat && last_row) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      ABORTED: begin
        bus.arr_clr = 1'b1;
`ifdef SYSTOLIC_SCHED_ABORT_EN
        bus.aborted = 1'b1;
`endif
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = ABORTED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nvec_reg      <= '0;
      vec_cnt_reg   <= '0;
      row_cnt_reg   <= '0;
      flush_cnt_reg <= '0;
      job_err_reg   <= 1'b0;
      wt_load_reg   <= 1'b0;
      wt_row_reg    <= '0;
      wt_data_reg   <= '0;
    end else begin
      job_err_reg <= (state_reg == IDLE) && bus.job_valid && !nvec_ok;
      wt_load_reg <= wt_beat;
      if (wt_beat) begin
        wt_row_reg  <= row_cnt_reg;
        wt_data_reg <= bus.wt_data;
      end
      if (job_take) begin
        nvec_reg      <= bus.job_nvec;
        vec_cnt_reg   <= '0;
        row_cnt_reg   <= '0;
        flush_cnt_reg <= '0;
      end
      // Row counter is rewound after the last weight so DRAIN starts at row 0;
      // in DRAIN it holds at N-1 after the final row.
      if (wt_beat) row_cnt_reg <= last_row ? '0 : row_cnt_reg + RW'(1);
      if (res_beat && !last_row) row_cnt_reg <= row_cnt_reg + RW'(1);
      if (in_beat && (vec_cnt_reg != nvec_reg)) vec_cnt_reg <= vec_cnt_reg + VW'(1);
      if ((state_reg == FLUSH) && !flush_end) flush_cnt_reg <= flush_cnt_reg + FW'(1);
      if (abort_hit) begin
        vec_cnt_reg   <= '0;
        row_cnt_reg   <= '0;
        flush_cnt_reg <= '0;
      end
    end
  end

  // Skew pipe: lane gi is a (gi+1)-deep shift register. It shifts every cycle,
  // injecting bubbles whenever no vector is accepted, so it drains to zero on
  // its own once STREAM ends.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DW-1:0] d_reg [gi+1];
      logic          v_reg [gi+1];
      always_ff @(posedge clk or posedge reset) begin
        if (reset || abort_hit) begin
          for (int s = 0; s <= gi; s++) begin
            d_reg[s] <= '0;
            v_reg[s] <= 1'b0;
          end
        end else begin
          d_reg[0] <= in_beat ? bus.in_data[gi*DW +: DW] : '0;
          v_reg[0] <= in_beat;
          for (int s = 1; s <= gi; s++) begin
            d_reg[s] <= d_reg[s-1];
            v_reg[s] <= v_reg[s-1];
          end
        end
      end
      assign lane_data[gi*DW +: DW] = d_reg[gi];
      assign lane_lv[gi]            = v_reg[gi];
    end
  endgenerate

  assign bus.job_err     = job_err_reg;
  assign bus.arr_wt_load = wt_load_reg;
  assign bus.arr_wt_row  = wt_row_reg;
  assign bus.arr_wt_data = wt_data_reg;
  assign bus.arr_in_data = lane_data;
  assign bus.arr_in_lv   = lane_lv;
  // Result side is zeroed outside DRAIN so idle/reset outputs are all zero.
  assign bus.arr_res_sel = (state_reg == DRAIN) ? row_cnt_reg : '0;
  assign bus.res_row     = (state_reg == DRAIN) ? row_cnt_reg : '0;
  assign bus.res_data    = (state_reg == DRAIN) ? bus.arr_res : '0;
endmodule

// File: tb/tb_systolic_job_sched.sv
module tb_systolic_job_sched;
  localparam int N = 4, DW = 4, ACCW = 8, VEC_MAX = 16, ARR_LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  systolic_job_sched_if #(.N(N), .DW(DW), .ACCW(ACCW), .VEC_MAX(VEC_MAX)) bus ();

  systolic_job_sched #(.N(N), .DW(DW), .ACCW(ACCW), .VEC_MAX(VEC_MAX), .ARR_LAT(ARR_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in array: the result row encodes its own row index.
  assign bus.arr_res = {4{4'hA, 2'b00, bus.arr_res_sel}};

  typedef struct {
    int   nvec;
    logic exp_err;
    logic exp_busy;
  } jvec_t;

  function automatic logic [31:0] res_exp(int r);
    logic [7:0] b;
    b = {4'hA, 2'b00, 2'(r)};
    return {4{b}};
  endfunction

  function automatic logic [15:0] wt_pat(int c);
    logic [15:0] p;
    for (int j = 0; j < 4; j++) p[j*4 +: 4] = 4'(c + 3 * j);
    return p;
  endfunction

  function automatic logic [15:0] in_pat(int c);
    logic [15:0] p;
    for (int j = 0; j < 4; j++) p[j*4 +: 4] = 4'(c - 5 + j);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.job_valid = 1'b0;
    bus.job_nvec  = '0;
    bus.wt_valid  = 1'b0;
    bus.wt_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
  endtask

  // Starts a job with all valids/readies high; returns cycles from accept to done.
  task automatic run_job(input int nvec, output int cyc);
    bus.job_valid = 1'b1;
    bus.job_nvec  = 5'(nvec);
    bus.wt_valid  = 1'b1;
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      bus.job_valid = 1'b0;
      if (bus.done) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    jvec_t       tbl [6];
    logic [6:0]  exp_ctl;
    logic [3:0]  exp_lv;
    logic [15:0] exp_in;
    int          cyc;
    int          src;
    logic        found;

    idle_inputs();
`ifdef SYSTOLIC_SCHED_ABORT_EN
    bus.abort = 1'b0;
`endif
    tbl[0] = '{0,  1'b1, 1'b0};
    tbl[1] = '{17, 1'b1, 1'b0};
    tbl[2] = '{31, 1'b1, 1'b0};
    tbl[3] = '{1,  1'b0, 1'b1};
    tbl[4] = '{16, 1'b0, 1'b1};
    tbl[5] = '{20, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_job_ready", bus.job_ready, 1);
    chk("rst_flags", {bus.busy, bus.done, bus.arr_clr, bus.wt_ready, bus.in_ready,
                      bus.res_valid, bus.job_err, bus.arr_wt_load}, 0);
    chk("rst_data", {bus.arr_in_data, bus.arr_in_lv, bus.arr_wt_data, bus.res_row}, 0);
    reset = 1'b0;
    step();

    // T3 descriptor table: invalid counts pulse job_err, valid ones start a job
    for (int i = 0; i < 6; i++) begin
      bus.job_valid = 1'b1;
      bus.job_nvec  = 5'(tbl[i].nvec);
      step();
      bus.job_valid = 1'b0;
      chk($sformatf("t3_err[%0d]", tbl[i].nvec), bus.job_err, tbl[i].exp_err);
      chk($sformatf("t3_busy[%0d]", tbl[i].nvec), bus.busy, tbl[i].exp_busy);
      chk($sformatf("t3_clr[%0d]", tbl[i].nvec), bus.arr_clr, tbl[i].exp_busy);
      step();
      chk($sformatf("t3_errpulse[%0d]", tbl[i].nvec), bus.job_err, 0);
      do_reset();
    end

    // T1/T2: nvec=4 with everything streaming; cycle 0 is the job accept cycle
    bus.job_valid = 1'b1;
    bus.job_nvec  = 5'd4;
    bus.wt_valid  = 1'b1;
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'b1;
    bus.wt_data   = wt_pat(0);
    bus.in_data   = in_pat(0);
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 1) bus.job_valid = 1'b0;
      exp_ctl = {k >= 22, k == 1, k >= 2 && k <= 5, k >= 6 && k <= 9,
                 k >= 17 && k <= 20, k == 21, k <= 21};
      chk($sformatf("t1_ctl[c%0d]", k), {bus.job_ready, bus.arr_clr, bus.wt_ready,
          bus.in_ready, bus.res_valid, bus.done, bus.busy}, exp_ctl);
      if (k >= 3 && k <= 6)
        chk($sformatf("t1_wt[c%0d]", k), {bus.arr_wt_load, bus.arr_wt_row, bus.arr_wt_data},
            {1'b1, 2'(k - 3), wt_pat(k - 1)});
      else
        chk($sformatf("t1_wtload[c%0d]", k), bus.arr_wt_load, 0);
      for (int j = 0; j < 4; j++) begin
        src = k - 1 - j;
        exp_lv[j] = (src >= 6 && src <= 9);
        exp_in[j*4 +: 4] = exp_lv[j] ? 4'(src - 5 + j) : 4'h0;
      end
      chk($sformatf("t2_skew[c%0d]", k), {bus.arr_in_lv, bus.arr_in_data}, {exp_lv, exp_in});
      if (k >= 17 && k <= 20)
        chk($sformatf("t1_res[c%0d]", k), {bus.res_row, bus.arr_res_sel, bus.res_data},
            {2'(k - 17), 2'(k - 17), res_exp(k - 17)});
      bus.wt_data = wt_pat(k);
      bus.in_data = in_pat(k);
    end

    // Boundary: maximum vector count
    run_job(16, cyc);
    chk("t1_nvec16_latency", cyc, 17 + 16);
    step();

    // T4: stall on result row 2
    bus.job_valid = 1'b1;
    bus.job_nvec  = 5'd1;
    bus.wt_valid  = 1'b1;
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      bus.job_valid = 1'b0;
      if (bus.res_valid && bus.res_row == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_reach_row2", found, 1);
    bus.res_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("t4_stall[%0d]", k), {bus.res_valid, bus.res_row, bus.res_data},
          {1'b1, 2'd2, res_exp(2)});
    end
    bus.res_ready = 1'b1;
    step();
    chk("t4_row3", {bus.res_row, bus.res_data}, {2'd3, res_exp(3)});
    step();
    chk("t4_done", bus.done, 1);
    step();
    chk("t4_idle", {bus.job_ready, bus.done}, 2'b10);

    // T5: async reset mid-STREAM after 3 of 8 vectors
    bus.job_valid = 1'b1;
    bus.job_nvec  = 5'd8;
    bus.in_data   = 16'h4321;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      bus.job_valid = 1'b0;
      if (bus.in_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_reach_stream", found, 1);
    repeat (3) step();
    chk("t5_streaming", {bus.in_ready, bus.arr_in_lv[0]}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_flags", {bus.job_ready, bus.busy, bus.done, bus.arr_clr, bus.wt_ready,
                         bus.in_ready, bus.res_valid, bus.job_err, bus.arr_wt_load}, 9'h100);
    chk("t5_rst_data", {bus.arr_in_data, bus.arr_in_lv, bus.arr_wt_data, bus.arr_wt_row,
                        bus.arr_res_sel, bus.res_row}, 0);
    chk("t5_rst_res", bus.res_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    chk("t5_no_done", {bus.done, bus.job_ready}, 2'b01);
    run_job(2, cyc);
    chk("t5_new_job_latency", cyc, 17 + 2);
    step();

`ifdef SYSTOLIC_SCHED_ABORT_EN
    // T6: abort in LOAD_W after 2 beats
    bus.job_valid = 1'b1;
    bus.job_nvec  = 5'd4;
    bus.wt_valid  = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      bus.job_valid = 1'b0;
      if (bus.wt_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_reach_loadw", found, 1);
    repeat (2) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t6_abort_cycle", {bus.arr_clr, bus.aborted, bus.wt_ready, bus.arr_wt_load, bus.done},
        5'b11000);
    step();
    chk("t6_idle", {bus.job_ready, bus.aborted, bus.done, bus.arr_clr}, 4'b1000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
